// File: rtl/lsu_store_merge.sv
// Load/store unit in front of a word-only data memory. Byte and half stores
// are done as read-modify-write; sub-word loads are extracted and extended.
// Misaligned accesses and illegal sizes return an error and touch no memory.
// Ports: clk, rst_n (sync, active-low); req_* request channel (valid/ready);
//   resp_* response channel (valid/ready); mem_* synchronous memory port
//   (read data one cycle after address).
// Optional: define LSU_PERF_CNT_EN to add saturating counters cnt_load,
//   cnt_store, cnt_rmw and cnt_err. cnt_store counts all successful stores,
//   cnt_rmw counts only the sub-word ones.
module lsu_store_merge #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [AWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DWIDTH-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DWIDTH-1:0]     mem_wdata,
  output logic [DWIDTH/8-1:0]   mem_wdata_mask,
  input  logic [DWIDTH-1:0]     mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           cnt_load,
  output logic [31:0]           cnt_store,
  output logic [31:0]           cnt_rmw,
  output logic [31:0]           cnt_err
`endif
);

  if (DWIDTH != 32) begin : g_bad_dwidth
    $error("lsu_store_merge: only DWIDTH=32 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [AWIDTH-1:0]   maddr_q, maddr_d;
  logic                wen_q, wen_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]          mask_q, mask_d;

  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [DWIDTH-1:0]   sdata_q, sdata_d;

  logic                err_in;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DWIDTH-1:0]   merged;
  logic [DWIDTH-1:0]   ext;

  always_comb begin
    err_in = (req_size == 2'd3)
           | ((req_size == 2'd1) & req_addr[0])
           | ((req_size == 2'd2) & (|req_addr[1:0]));

    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];

    merged = mem_rdata;
    if (size_q == 2'd0) begin
      merged[{off_q, 3'b000} +: 8] = sdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = sdata_q[15:0];
    end

    unique case (size_q)
      2'd0:    ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'd1:    ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    maddr_d      = maddr_q;
    wdata_d      = wdata_q;
    wen_d        = 1'b0;
    mask_d       = 4'h0;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    sdata_d      = sdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          off_d       = req_addr[1:0];
          sdata_d     = req_wdata;
          req_ready_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          if (err_in) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
          end else if (req_we && req_size == 2'd2) begin
            // Full aligned word: no need to read first.
            state_d = S_WRITE;
            maddr_d = {req_addr[AWIDTH-1:2], 2'b00};
            wen_d   = 1'b1;
            mask_d  = 4'hF;
            wdata_d = req_wdata;
          end else begin
            state_d = S_READ;
            maddr_d = {req_addr[AWIDTH-1:2], 2'b00};
          end
        end
      end
      S_READ: begin
        state_d = S_MODIFY;
      end
      S_MODIFY: begin
        if (we_q) begin
          state_d = S_WRITE;
          wen_d   = 1'b1;
          mask_d  = 4'hF;
          wdata_d = merged;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = ext;
        end
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      maddr_q      <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      mask_q       <= 4'h0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      sdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      maddr_q      <= maddr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      sdata_q      <= sdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_addr       = maddr_q;
  assign mem_wdata      = wdata_q;
  // Gate with reset so no write can slip out while rst_n is low.
  assign mem_wen        = wen_q & rst_n;
  assign mem_wdata_mask = mask_q & {4{rst_n}};

`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_load_q, cnt_load_d;
  logic [31:0] cnt_store_q, cnt_store_d;
  logic [31:0] cnt_rmw_q, cnt_rmw_d;
  logic [31:0] cnt_err_q, cnt_err_d;
  logic        to_resp;

  always_comb begin
    cnt_load_d  = cnt_load_q;
    cnt_store_d = cnt_store_q;
    cnt_rmw_d   = cnt_rmw_q;
    cnt_err_d   = cnt_err_q;
    to_resp     = (state_d == S_RESP) && (state_q != S_RESP);
    if (to_resp) begin
      if (state_q == S_IDLE) begin
        if (cnt_err_d != '1) cnt_err_d = cnt_err_q + 32'd1;
      end else if (state_q == S_MODIFY) begin
        if (cnt_load_d != '1) cnt_load_d = cnt_load_q + 32'd1;
      end else begin
        if (cnt_store_d != '1) cnt_store_d = cnt_store_q + 32'd1;
        if (size_q != 2'd2 && cnt_rmw_d != '1) cnt_rmw_d = cnt_rmw_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_rmw_q   <= '0;
      cnt_err_q   <= '0;
    end else begin
      cnt_load_q  <= cnt_load_d;
      cnt_store_q <= cnt_store_d;
      cnt_rmw_q   <= cnt_rmw_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_rmw   = cnt_rmw_q;
  assign cnt_err   = cnt_err_q;
`endif

endmodule

// File: tb/tb_lsu_store_merge.sv
// Self-checking bench for lsu_store_merge: directed scenarios plus random
// requests checked against a byte-array reference model.
module tb_lsu_store_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wdata_mask;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_store_merge #(.AWIDTH(8), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wdata_mask(mem_wdata_mask),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous read, word write, plus a backdoor for setup.
  logic [31:0] mem [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_val = 32'd0;
  int          wr_cnt = 0;
  logic [7:0]  wr_addr = 8'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_mask = 4'd0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_wen) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
      wr_mask <= mem_wdata_mask;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_val;
    end
  end

  // Reference memory, byte granular.
  logic [7:0] rmem [0:255];

  task automatic set_word(input int idx, input logic [31:0] v);
    bd_we = 1'b1;
    bd_idx = idx[5:0];
    bd_val = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++) rmem[idx*4+i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] ad);
    logic [31:0] w;
    int b;
    b = int'(ad) & 252;
    w = {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    return w;
  endfunction

  task automatic ref_op(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [7:0] ad,
                        input logic [31:0] wd,
                        output logic e_err, output logic [31:0] e_rd,
                        output int e_lat, output int e_wr);
    int nb;
    int a;
    logic [31:0] v;
    a = int'(ad);
    e_err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
            (sz == 2'd2 && a % 4 != 0);
    e_rd = 32'd0;
    e_wr = 0;
    e_lat = 1;
    if (!e_err) begin
      nb = 1 << sz;
      if (we) begin
        for (int i = 0; i < nb; i++) rmem[a+i] = wd[8*i +: 8];
        e_wr = 1;
        e_lat = (nb == 4) ? 2 : 4;
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(rmem[a+i]) << (8*i));
        if (!uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        e_rd = v;
        e_lat = 3;
      end
    end
  endtask

  // Drives one request and observes it; comparisons are made by callers.
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [7:0] ad,
                       input logic [31:0] wd, input int hold,
                       output int lat, output logic [31:0] rd,
                       output logic er, output int nwr,
                       output logic stable, output logic idle_after);
    int w0;
    int t;
    w0 = wr_cnt;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = ad;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = 8'($urandom);
    req_wdata = $urandom;
    stable = 1'b1;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (req_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== rd ||
          resp_err !== er || req_ready !== 1'b0) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    idle_after = (req_ready === 1'b1) && (resp_valid === 1'b0);
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hs got %b want 100",
               {req_ready, resp_valid, resp_err});
    end
    n_checks++;
    if (resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h want 0", resp_rdata);
    end
    n_checks++;
    if ({mem_wen, mem_addr, mem_wdata, mem_wdata_mask} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_mem got wen=%b a=%h d=%h m=%h want all 0",
               mem_wen, mem_addr, mem_wdata, mem_wdata_mask);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sub_store;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    set_word(1, 32'h1122_3344);
    ref_op(1'b1, 2'd0, 1'b0, 8'h05, 32'h0000_00AB, ee, erd, el, ew);
    issue(1'b1, 2'd0, 1'b0, 8'h05, 32'h0000_00AB, 0, lat, rd, er, nwr, st, ok);
    n_checks++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sb_resp got lat=%0d err=%b rd=%h want 4 0 0",
               lat, er, rd);
    end
    n_checks++;
    if (nwr !== 1 || wr_addr !== 8'h04 || wr_data !== 32'h1122_AB44 ||
        wr_mask !== 4'hF) begin
      n_fail++;
      $display("FAIL sb_write got n=%0d a=%h d=%h m=%h want 1 04 1122ab44 f",
               nwr, wr_addr, wr_data, wr_mask);
    end
    n_checks++;
    if (mem[1] !== 32'h1122_AB44 || !ok) begin
      n_fail++;
      $display("FAIL sb_mem got %h idle=%b want 1122ab44 1", mem[1], ok);
    end
  endtask

  task automatic test_load_half;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    logic [31:0] want [2];
    want[0] = 32'hFFFF_80FF;
    want[1] = 32'h0000_80FF;
    set_word(2, 32'h80FF_7F01);
    for (int u = 0; u < 2; u++) begin
      ref_op(1'b0, 2'd1, 1'(u), 8'h0A, 32'd0, ee, erd, el, ew);
      issue(1'b0, 2'd1, 1'(u), 8'h0A, 32'd0, 0, lat, rd, er, nwr, st, ok);
      n_checks++;
      if (rd !== want[u] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL lh_data u=%0d got %h err=%b want %h 0",
                 u, rd, er, want[u]);
      end
      n_checks++;
      if (lat !== 3 || nwr !== 0) begin
        n_fail++;
        $display("FAIL lh_timing u=%0d got lat=%0d wr=%0d want 3 0",
                 u, lat, nwr);
      end
    end
  endtask

  task automatic test_word_store;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    ref_op(1'b1, 2'd2, 1'b0, 8'h0C, 32'hDEAD_BEEF, ee, erd, el, ew);
    issue(1'b1, 2'd2, 1'b0, 8'h0C, 32'hDEAD_BEEF, 0, lat, rd, er, nwr, st, ok);
    n_checks++;
    if (lat !== 2 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_resp got lat=%0d err=%b want 2 0", lat, er);
    end
    n_checks++;
    if (nwr !== 1 || wr_addr !== 8'h0C || wr_mask !== 4'hF ||
        mem[3] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_write got n=%0d a=%h m=%h mem=%h want 1 0c f deadbeef",
               nwr, wr_addr, wr_mask, mem[3]);
    end
  endtask

  task automatic test_errors;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    logic [7:0] a0;
    logic       ew_t [3];
    logic [1:0] sz_t [3];
    logic [7:0] ad_t [3];
    ew_t[0] = 1'b0; sz_t[0] = 2'd2; ad_t[0] = 8'h06;
    ew_t[1] = 1'b1; sz_t[1] = 2'd1; ad_t[1] = 8'h03;
    ew_t[2] = 1'b0; sz_t[2] = 2'd3; ad_t[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      a0 = mem_addr;
      ref_op(ew_t[k], sz_t[k], 1'b0, ad_t[k], 32'h5A5A_5A5A, ee, erd, el, ew);
      issue(ew_t[k], sz_t[k], 1'b0, ad_t[k], 32'h5A5A_5A5A, 0,
            lat, rd, er, nwr, st, ok);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
        n_fail++;
        $display("FAIL err_resp k=%0d got err=%b rd=%h lat=%0d want 1 0 1",
                 k, er, rd, lat);
      end
      n_checks++;
      if (nwr !== 0 || mem_addr !== a0) begin
        n_fail++;
        $display("FAIL err_nomem k=%0d got wr=%0d addr=%h want 0 %h",
                 k, nwr, mem_addr, a0);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    ref_op(1'b0, 2'd0, 1'b0, 8'h07, 32'd0, ee, erd, el, ew);
    issue(1'b0, 2'd0, 1'b0, 8'h07, 32'd0, 5, lat, rd, er, nwr, st, ok);
    n_checks++;
    if (st !== 1'b1 || ok !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable got stable=%b idle=%b want 1 1", st, ok);
    end
    n_checks++;
    if (rd !== erd || lat !== 3) begin
      n_fail++;
      $display("FAIL bp_data got %h lat=%0d want %h 3", rd, lat, erd);
    end
  endtask

  task automatic test_random;
    int lat, nwr, el, ew;
    logic [31:0] rd, erd;
    logic er, st, ok, ee;
    logic we, uns;
    logic [1:0] sz;
    logic [7:0] ad;
    logic [31:0] wd;
    int hold;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      uns = 1'($urandom);
      ad = 8'($urandom);
      wd = $urandom;
      hold = $urandom_range(0, 2);
      ref_op(we, sz, uns, ad, wd, ee, erd, el, ew);
      issue(we, sz, uns, ad, wd, hold, lat, rd, er, nwr, st, ok);
      n_checks++;
      if (rd !== erd || er !== ee || lat !== el || nwr !== ew ||
          st !== 1'b1 || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_%0d we=%b sz=%0d a=%h got rd=%h e=%b l=%0d w=%0d s=%b i=%b want %h %b %0d %0d 1 1",
                 n, we, sz, ad, rd, er, lat, nwr, st, ok, erd, ee, el, ew);
      end
      n_checks++;
      if (mem[ad[7:2]] !== ref_word(ad)) begin
        n_fail++;
        $display("FAIL rnd_mem_%0d a=%h got %h want %h",
                 n, ad, mem[ad[7:2]], ref_word(ad));
      end
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    set_word(5, 32'h5566_7788);
    w0 = wr_cnt;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 8'h15;
    req_wdata = 32'h0000_00CC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_wen got %b want 0", mem_wen);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_wen} !== 4'b1000 ||
        resp_rdata !== 32'd0 || mem_addr !== 8'd0 ||
        mem_wdata !== 32'd0 || mem_wdata_mask !== 4'd0) begin
      n_fail++;
      $display("FAIL rm_outs got rr=%b rv=%b re=%b w=%b rd=%h a=%h d=%h m=%h want reset values",
               req_ready, resp_valid, resp_err, mem_wen, resp_rdata,
               mem_addr, mem_wdata, mem_wdata_mask);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wr_cnt !== w0 || mem[5] !== 32'h5566_7788) begin
      n_fail++;
      $display("FAIL rm_mem got writes=%0d mem=%h want 0 55667788",
               wr_cnt - w0, mem[5]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 8'd0;
    req_wdata = 32'd0;
    resp_ready = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    test_reset();
    test_sub_store();
    test_load_half();
    test_word_store();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_store_merge.md
Name: lsu_store_merge

Overview:
- Load/store unit that sits directly upstream of the data memory; takes one load/store request at a time from the execute stage and drives the memory port.
- The memory only accepts word-aligned writes, and its byte mask is limited to low-aligned values (0/1/3/15). This block therefore performs read-modify-write for byte and half-word stores.
- Extracts and sign- or zero-extends byte and half-word loads.
- Flags misaligned accesses as errors instead of issuing them.

Parameters:
- AWIDTH, 8, byte address width of the data memory.
- DWIDTH, 32, data width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and gives an error.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  AWIDTH  byte address.
- req_wdata  input  DWIDTH  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  DWIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned access or illegal size.
- mem_addr  output  AWIDTH  word-aligned address, low 2 bits always 0.
- mem_wen  output  1  memory write enable.
- mem_wdata  output  DWIDTH  memory write data.
- mem_wdata_mask  output  DWIDTH/8  4'hF when mem_wen is 1, else 4'h0.
- mem_rdata  input  DWIDTH  memory read data, valid exactly one cycle after mem_addr is presented.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: FSM in IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_wen=0, mem_addr=0, mem_wdata=0, mem_wdata_mask=0.
- Write suppression in reset: mem_wen is combinationally gated with rst_n, so no write occurs in any cycle where rst_n=0.
- Reset mid-operation: aborts any in-flight read-modify-write. Memory is untouched unless the WRITE cycle had already completed.
- Captured fields: off=addr[1:0]; aligned address A=addr with bits [1:0] cleared.
- Misaligned rules: half with off[0]=1 is misaligned; word with off!=0 is misaligned; size 3 is an error.
- IDLE: req_ready=1. On req_valid&&req_ready, capture the request, then:
  - error -> RESP with resp_err=1;
  - aligned word store -> WRITE;
  - anything else -> READ.
- READ: mem_addr=A, mem_wen=0. Next state is MODIFY.
- MODIFY: mem_rdata is valid this cycle.
  - Store: register the merged word. Lanes selected by size/off take req_wdata low bytes; other lanes keep mem_rdata. Next state WRITE.
  - Load: register the extracted lane (byte lane off, or half lane off[1]), extended per req_unsigned. Next state RESP.
- WRITE: mem_addr=A, mem_wen=1, mask=4'hF, mem_wdata = merged word (or req_wdata for an aligned word store). Next state RESP.
- RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready. On resp_ready, go to IDLE. A new request can be accepted no earlier than the next cycle.
- Latency, from accept edge to resp_valid:
  - error: 1 cycle;
  - aligned word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- Outside WRITE: mem_wen=0 and mask=0.
- Outside READ/WRITE: mem_addr holds its last value.
- Backpressure: at most one request in flight. req_ready=0 in every state except IDLE.
- Request stability: req_* are not required to be stable after acceptance; everything needed is captured.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined: adds 32-bit saturating output counters cnt_load, cnt_store, cnt_rmw and cnt_err. Each increments on entry to RESP for its class; cnt_rmw counts sub-word stores. All clear on reset.
- When undefined: these ports and their logic do not exist, and the other ports behave identically.

Test Plan:
- Mem[0x04]=0x11223344; store byte 0xAB at 0x05 -> one READ at 0x04, then WRITE 0x04 data 0x1122AB44 mask 0xF; resp_valid 4 cycles after accept, resp_err=0.
- Mem[0x08]=0x80FF7F01; load half at 0x0A, unsigned=0 -> resp_rdata=0xFFFF80FF; same with unsigned=1 -> 0x000080FF; 3-cycle latency, no mem_wen.
- Store word 0xDEADBEEF at 0x0C -> no READ; WRITE at 0x0C, mask 0xF, resp 2 cycles after accept.
- Load word at 0x06 -> resp_err=1 and resp_rdata=0 after 1 cycle, with no memory access; same for store half at 0x03 and for size=3.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable, req_ready=0 throughout; accept occurs only after the handshake.
- Assert rst_n=0 during MODIFY of a sub-word store -> mem_wen never goes high, memory word unchanged, all outputs at reset values next cycle, req_ready=1.
